// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and digit width helpers for the countdown timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} timer_state_t;
  localparam int SEC_W = $clog2(60);
  localparam int MIN_W = $clog2(60);
  function automatic int digit_w(input int limit);
    return $clog2(limit);
  endfunction
endpackage

// File: rtl/countdown_timer_down_counter.sv
// down_counter_foo: one loadable down-counting digit field that wraps 0 -> LIMIT-1
module down_counter_foo #(
  parameter int LIMIT = 60,
  parameter int W = $clog2(LIMIT)
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iEn,
  input  logic         iLoad,
  input  logic [W-1:0] iLoadVal,
  output logic [W-1:0] oValue,
  output logic         oBorrow
);
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) oValue <= '0;
    else if (iLoad) oValue <= iLoadVal;
    else if (iEn) oValue <= (oValue == '0) ? W'(LIMIT - 1) : oValue - 1'b1;
  assign oBorrow = iEn && (oValue == '0);
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS countdown driven by a 1 Hz strobe, with run/pause control
// and a registered expiry pulse and level.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int SEC_LIMIT = 60,
  parameter int MIN_LIMIT = 60
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iTick,
  input  logic                         iLoad,
  input  logic [$clog2(MIN_LIMIT)-1:0] iLoadMin,
  input  logic [$clog2(SEC_LIMIT)-1:0] iLoadSec,
  input  logic                         iStart,
  input  logic                         iStop,
  output logic [$clog2(MIN_LIMIT)-1:0] oMin,
  output logic [$clog2(SEC_LIMIT)-1:0] oSec,
  output logic                         oRunning,
  output logic                         oDone,
  output logic                         oExpired
);
  localparam int SW = digit_w(SEC_LIMIT);
  localparam int MW = digit_w(MIN_LIMIT);
  timer_state_t r_state, w_next;
  logic w_nz, w_go, w_dec, w_last, w_load, w_sec_borrow, w_min_borrow;
  logic [SW-1:0] w_lsec;
  logic [MW-1:0] w_lmin;
  assign w_nz   = (oMin != '0) || (oSec != '0);
  assign w_load = iLoad && (r_state != RUN);
  assign w_go   = iStart && !iStop && !iLoad && w_nz;
  assign w_dec  = (r_state == RUN) && iTick && !iStop && w_nz;
  assign w_last = w_dec && (oMin == '0) && (oSec == SW'(1));
  assign w_lsec = (int'(iLoadSec) >= SEC_LIMIT) ? SW'(SEC_LIMIT - 1) : iLoadSec;
  assign w_lmin = (int'(iLoadMin) >= MIN_LIMIT) ? MW'(MIN_LIMIT - 1) : iLoadMin;
  // Minutes borrow can only fire if the zero guard failed; treat it as expiry too.
  always_comb
    w_next = (r_state == IDLE && w_go)                         ? RUN     :
             (r_state == RUN && iStop)                          ? PAUSE   :
             (r_state == RUN && (w_last || w_min_borrow))       ? EXPIRED :
             (r_state == PAUSE && w_go)                         ? RUN     :
             (r_state == EXPIRED && iLoad)                      ? IDLE    : r_state;
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      r_state  <= IDLE;
      oRunning <= 1'b0;
      oDone    <= 1'b0;
      oExpired <= 1'b0;
    end else begin
      r_state  <= w_next;
      oRunning <= (w_next == RUN);
      oDone    <= w_last;
      oExpired <= (w_next == EXPIRED);
    end
  down_counter_foo #(.LIMIT(SEC_LIMIT), .W(SW)) u_sec (
    .iClk(iClk), .iRst(iRst), .iEn(w_dec), .iLoad(w_load),
    .iLoadVal(w_lsec), .oValue(oSec), .oBorrow(w_sec_borrow)
  );
  down_counter_foo #(.LIMIT(MIN_LIMIT), .W(MW)) u_min (
    .iClk(iClk), .iRst(iRst), .iEn(w_sec_borrow), .iLoad(w_load),
    .iLoadVal(w_lmin), .oValue(oMin), .oBorrow(w_min_borrow)
  );
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer at the default 60/60 limits
module tb_countdown_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [5:0] lmin = '0, lsec = '0;
  logic [5:0] o_min, o_sec;
  logic o_run, o_done, o_exp;
  typedef struct packed {logic [5:0] m; logic [5:0] s; logic r; logic d; logic e;} obs_t;
  obs_t sb[$];
  obs_t oq[$];
  string nq[$];
  int passed = 0, total = 0;

  countdown_timer dut (
    .iClk(clk), .iRst(rst), .iTick(tick), .iLoad(load), .iLoadMin(lmin), .iLoadSec(lsec),
    .iStart(start), .iStop(stop), .oMin(o_min), .oSec(o_sec), .oRunning(o_run),
    .oDone(o_done), .oExpired(o_exp)
  );

  always #5 clk = ~clk;

  function automatic obs_t ex(input int m, input int s, input bit r, input bit d, input bit e);
    obs_t x;
    x.m = 6'(m); x.s = 6'(s); x.r = r; x.d = d; x.e = e;
    return x;
  endfunction

  function automatic obs_t now();
    obs_t x;
    x.m = o_min; x.s = o_sec; x.r = o_run; x.d = o_done; x.e = o_exp;
    return x;
  endfunction

  task automatic cyc(input string name, input obs_t e, input bit t, input bit st, input bit sp,
                     input bit ld, input int m, input int s);
    @(negedge clk);
    tick = t; start = st; stop = sp; load = ld; lmin = 6'(m); lsec = 6'(s);
    sb.push_back(e);
    nq.push_back(name);
    @(posedge clk);
    #1;
    oq.push_back(now());
  endtask

  task automatic test_reset();
    sb.push_back(ex(0, 0, 0, 0, 0)); nq.push_back("reset"); oq.push_back(now());
    @(negedge clk); rst = 1'b0;
    cyc("reset_idle_tick", ex(0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      obs_t e = sb.pop_front(), g = oq.pop_front(); string n = nq.pop_front();
      total++;
      if (g !== e) $display("FAIL %s got=%h want=%h", n, g, e); else passed++;
    end
  endtask

  task automatic test_basic();
    cyc("b_load", ex(0, 3, 0, 0, 0), 0, 0, 0, 1, 0, 3);
    cyc("b_start", ex(0, 3, 1, 0, 0), 0, 1, 0, 0, 0, 0);
    cyc("b_t1", ex(0, 2, 1, 0, 0), 1, 0, 0, 0, 0, 0);
    cyc("b_t2", ex(0, 1, 1, 0, 0), 1, 0, 0, 0, 0, 0);
    cyc("b_t3", ex(0, 0, 0, 1, 1), 1, 0, 0, 0, 0, 0);
    cyc("b_after", ex(0, 0, 0, 0, 1), 0, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      obs_t e = sb.pop_front(), g = oq.pop_front(); string n = nq.pop_front();
      total++;
      if (g !== e) $display("FAIL %s got=%h want=%h", n, g, e); else passed++;
    end
  endtask

  task automatic test_borrow();
    int m = 2, s = 0;
    cyc("w_load", ex(2, 0, 0, 0, 0), 0, 0, 0, 1, 2, 0);
    cyc("w_start", ex(2, 0, 1, 0, 0), 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 120; i++) begin
      if (s == 0) begin s = 59; m--; end else s--;
      if (m == 0 && s == 0) cyc("w_last", ex(0, 0, 0, 1, 1), 1, 0, 0, 0, 0, 0);
      else cyc("w_tick", ex(m, s, 1, 0, 0), 1, 0, 0, 0, 0, 0);
    end
    cyc("w_hold", ex(0, 0, 0, 0, 1), 1, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      obs_t e = sb.pop_front(), g = oq.pop_front(); string n = nq.pop_front();
      total++;
      if (g !== e) $display("FAIL %s got=%h want=%h", n, g, e); else passed++;
    end
  endtask

  task automatic test_pause();
    cyc("p_load", ex(0, 10, 0, 0, 0), 0, 0, 0, 1, 0, 10);
    cyc("p_start", ex(0, 10, 1, 0, 0), 0, 1, 0, 0, 0, 0);
    cyc("p_stop_tick", ex(0, 10, 0, 0, 0), 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("p_tick_ign", ex(0, 10, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    cyc("p_resume", ex(0, 10, 1, 0, 0), 0, 1, 0, 0, 0, 0);
    cyc("p_dec", ex(0, 9, 1, 0, 0), 1, 0, 0, 0, 0, 0);
    cyc("p_run_load_ign", ex(0, 9, 1, 0, 0), 0, 0, 0, 1, 3, 3);
    cyc("p_stop", ex(0, 9, 0, 0, 0), 0, 0, 1, 0, 0, 0);
    cyc("p_pause_load", ex(1, 0, 0, 0, 0), 1, 1, 0, 1, 1, 0);
    while (sb.size() > 0) begin
      obs_t e = sb.pop_front(), g = oq.pop_front(); string n = nq.pop_front();
      total++;
      if (g !== e) $display("FAIL %s got=%h want=%h", n, g, e); else passed++;
    end
  endtask

  task automatic test_clamp();
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    cyc("c_clamp_max", ex(59, 59, 0, 0, 0), 0, 0, 0, 1, 63, 63);
    cyc("c_clamp_edge", ex(59, 59, 0, 0, 0), 0, 0, 0, 1, 60, 60);
    cyc("c_inrange", ex(58, 1, 0, 0, 0), 0, 0, 0, 1, 58, 1);
    cyc("c_zero_load", ex(0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 0);
    cyc("c_zero_start", ex(0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0);
    cyc("c_load_beats_start", ex(0, 5, 0, 0, 0), 0, 1, 0, 1, 0, 5);
    cyc("c_idle_tick", ex(0, 5, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      obs_t e = sb.pop_front(), g = oq.pop_front(); string n = nq.pop_front();
      total++;
      if (g !== e) $display("FAIL %s got=%h want=%h", n, g, e); else passed++;
    end
  endtask

  task automatic test_async_reset();
    cyc("r_start", ex(0, 5, 1, 0, 0), 0, 1, 0, 0, 0, 0);
    cyc("r_tick", ex(0, 4, 1, 0, 0), 1, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    sb.push_back(ex(0, 0, 0, 0, 0)); nq.push_back("r_async"); oq.push_back(now());
    @(negedge clk); tick = 1'b1;
    @(negedge clk); rst = 1'b0;
    cyc("r_after", ex(0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      obs_t e = sb.pop_front(), g = oq.pop_front(); string n = nq.pop_front();
      total++;
      if (g !== e) $display("FAIL %s got=%h want=%h", n, g, e); else passed++;
    end
  endtask

  task automatic test_expired();
    cyc("x_load", ex(0, 1, 0, 0, 0), 0, 0, 0, 1, 0, 1);
    cyc("x_start", ex(0, 1, 1, 0, 0), 0, 1, 0, 0, 0, 0);
    cyc("x_done", ex(0, 0, 0, 1, 1), 1, 0, 0, 0, 0, 0);
    cyc("x_start_ign", ex(0, 0, 0, 0, 1), 0, 1, 0, 0, 0, 0);
    cyc("x_tick_ign", ex(0, 0, 0, 0, 1), 1, 0, 0, 0, 0, 0);
    cyc("x_reload", ex(0, 2, 0, 0, 0), 0, 1, 0, 1, 0, 2);
    cyc("x_restart", ex(0, 2, 1, 0, 0), 0, 1, 0, 0, 0, 0);
    cyc("x_b2b1", ex(0, 1, 1, 0, 0), 1, 0, 0, 0, 0, 0);
    cyc("x_b2b2", ex(0, 0, 0, 1, 1), 1, 0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      obs_t e = sb.pop_front(), g = oq.pop_front(); string n = nq.pop_front();
      total++;
      if (g !== e) $display("FAIL %s got=%h want=%h", n, g, e); else passed++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_borrow();
    test_pause();
    test_clamp();
    test_async_reset();
    test_expired();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
